// File: rtl/message_serializer.sv
// Buffers message-passer result bundles in a small FIFO and streams each one out
// as BUS_WIDTH-bit beats (horizontal vector first, then vertical) on valid/ready.
module message_serializer #(
  parameter int unsigned LABELS          = 16,
  parameter int unsigned MESSAGE_WIDTH   = 6,
  parameter int unsigned BUS_WIDTH       = 32,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              valid,
  input  logic [LABELS*MESSAGE_WIDTH-1:0]   horizontal_out,
  input  logic [LABELS*MESSAGE_WIDTH-1:0]   vertical_out,
  output logic [BUS_WIDTH-1:0]              out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_vertical,
  output logic                              out_last,
  output logic [FIFO_DEPTH_LOG2:0]          fifo_count,
  output logic                              overflow
);

  localparam int unsigned VEC_W  = LABELS * MESSAGE_WIDTH;
  localparam int unsigned BEATS  = VEC_W / BUS_WIDTH;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned PTR_W  = FIFO_DEPTH_LOG2;
  localparam int unsigned CNT_W  = FIFO_DEPTH_LOG2 + 1;

  if ((VEC_W % BUS_WIDTH) != 0) begin : g_bad_bus_width
    $error("LABELS*MESSAGE_WIDTH must be a multiple of BUS_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, SEND_H, SEND_V} state_e;

  state_e                 state_q, state_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic [BUS_WIDTH-1:0]   out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_vertical_q, out_vertical_d;
  logic                   out_last_q, out_last_d;

  logic [2*VEC_W-1:0]     mem_q [DEPTH];
  logic [2*VEC_W-1:0]     in_bundle, head_bundle, next_bundle;
  logic                   hs, cap, pop;

  function automatic logic [BUS_WIDTH-1:0] slice_beat(input logic [VEC_W-1:0] vec,
                                                      input logic [31:0]      idx);
    return BUS_WIDTH'(vec >> (idx * BUS_WIDTH));
  endfunction

  always_comb begin
    in_bundle   = {vertical_out, horizontal_out};
    head_bundle = mem_q[rd_ptr_q];
    // With one bundle left, the follow-on bundle can only be the one arriving now
    next_bundle = (count_q == CNT_W'(1)) ? in_bundle : mem_q[rd_ptr_q + PTR_W'(1)];
    hs          = out_valid_q && out_ready;
    cap         = valid && (count_q != CNT_W'(DEPTH));
    pop         = 1'b0;

    state_d        = state_q;
    beat_d         = beat_q;
    out_data_d     = out_data_q;
    out_valid_d    = out_valid_q;
    out_vertical_d = out_vertical_q;
    out_last_d     = out_last_q;
    overflow_d     = overflow_q | (valid && !cap);

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d        = SEND_H;
          beat_d         = '0;
          out_valid_d    = 1'b1;
          out_data_d     = slice_beat(head_bundle[VEC_W-1:0], 32'd0);
          out_vertical_d = 1'b0;
          out_last_d     = 1'b0;
        end
      end
      SEND_H: begin
        if (hs) begin
          if (32'(beat_q) == BEATS - 1) begin
            state_d        = SEND_V;
            beat_d         = '0;
            out_data_d     = slice_beat(head_bundle[2*VEC_W-1:VEC_W], 32'd0);
            out_vertical_d = 1'b1;
            out_last_d     = (BEATS == 1);
          end else begin
            beat_d     = beat_q + BEAT_W'(1);
            out_data_d = slice_beat(head_bundle[VEC_W-1:0], 32'(beat_q) + 32'd1);
          end
        end
      end
      SEND_V: begin
        if (hs) begin
          if (32'(beat_q) == BEATS - 1) begin
            pop = 1'b1;
            if ((count_q > CNT_W'(1)) || cap) begin
              state_d        = SEND_H;
              beat_d         = '0;
              out_data_d     = slice_beat(next_bundle[VEC_W-1:0], 32'd0);
              out_vertical_d = 1'b0;
              out_last_d     = 1'b0;
            end else begin
              state_d        = IDLE;
              beat_d         = '0;
              out_valid_d    = 1'b0;
              out_data_d     = '0;
              out_vertical_d = 1'b0;
              out_last_d     = 1'b0;
            end
          end else begin
            beat_d     = beat_q + BEAT_W'(1);
            out_data_d = slice_beat(head_bundle[2*VEC_W-1:VEC_W], 32'(beat_q) + 32'd1);
            out_last_d = (32'(beat_q) + 32'd1 == BEATS - 1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = cap ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(cap) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      beat_q         <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      overflow_q     <= 1'b0;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      out_vertical_q <= 1'b0;
      out_last_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      beat_q         <= beat_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      overflow_q     <= overflow_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      out_vertical_q <= out_vertical_d;
      out_last_q     <= out_last_d;
    end
  end

  // Bundle storage needs no reset; occupancy is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (cap) mem_q[wr_ptr_q] <= in_bundle;
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_vertical = out_vertical_q;
  assign out_last     = out_last_q;
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;

endmodule

// File: doc/message_serializer.md
Name: message_serializer

Overview:
- Sits on the output side of sequencial_message_passer and consumes its valid/horizontal_out/vertical_out result stream.
- The passer has no backpressure, so each result bundle is captured into a small FIFO.
- Each bundle is then serialized into BUS_WIDTH-bit beats on a valid/ready stream toward the message-memory writer.
- Reports overflow, meaning a bundle dropped because the FIFO was full.

Parameters:
- LABELS, 16, labels per message vector
- MESSAGE_WIDTH, 6, bits per label message
- BUS_WIDTH, 32, output beat width; LABELS*MESSAGE_WIDTH must be a multiple of BUS_WIDTH (elaboration error otherwise)
- FIFO_DEPTH_LOG2, 2, FIFO holds 2**FIFO_DEPTH_LOG2 bundles

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- valid  in  1  passer result strobe, one bundle per cycle when high
- horizontal_out  in  LABELS*MESSAGE_WIDTH  horizontal message vector; label i occupies bits [(i+1)*MESSAGE_WIDTH-1 -: MESSAGE_WIDTH]
- vertical_out  in  LABELS*MESSAGE_WIDTH  vertical message vector, same packing
- out_data  out  BUS_WIDTH  current beat
- out_valid  out  1  beat valid
- out_ready  in  1  sink accepts beat
- out_vertical  out  1  0 = beat from horizontal vector, 1 = from vertical vector
- out_last  out  1  final beat of the bundle
- fifo_count  out  FIFO_DEPTH_LOG2+1  bundles stored, including the one being sent
- overflow  out  1  sticky drop flag

Behaviour:
Reset (rst==0 at posedge):
- out_valid=0, out_data=0, out_vertical=0, out_last=0, fifo_count=0, overflow=0.
- FIFO pointers and beat counter are cleared; state goes to IDLE.
- Reset mid-transfer discards all stored bundles and the partial bundle; nothing is resumed.

Beats per bundle:
- B = LABELS*MESSAGE_WIDTH/BUS_WIDTH beats per vector.
- 2B beats per bundle (defaults: B=3, 6 beats).

Capture:
- On posedge with valid=1 and fifo_count < 2**FIFO_DEPTH_LOG2, {vertical_out, horizontal_out} is written at the write pointer.
- If fifo_count equals depth, the bundle is dropped and overflow is set to 1 until reset.
- Full is evaluated on the registered count, so a bundle arriving while full is dropped even if a pop occurs in the same cycle.

FSM:
- IDLE: out_valid=0. If fifo_count>0, load the head bundle and go to SEND_H with beat=0.
- SEND_H: out_data = horizontal[(beat+1)*BUS_WIDTH-1 -: BUS_WIDTH], out_vertical=0.
- SEND_V: same slicing from the vertical vector, out_vertical=1.
- A beat completes on a posedge with out_valid && out_ready; beat then increments.
- At beat==B-1 in SEND_H, go to SEND_V with beat=0.
- At beat==B-1 in SEND_V, out_last=1. On completion the bundle is popped. If more bundles remain, go straight to SEND_H beat 0 of the next bundle (no idle bubble); otherwise go to IDLE.

Latency and output stability:
- A bundle captured into an empty FIFO at posedge N gives out_valid=1 with beat 0 after posedge N+1.
- Sustained throughput is one beat per cycle with out_ready held at 1.
- While out_valid && !out_ready, out_data, out_vertical and out_last hold stable.
- out_valid never drops without a handshake, except on reset.

fifo_count:
- Increments on capture and decrements on the last-beat handshake.
- Capture and pop in the same cycle leave it unchanged.

Data path:
- No arithmetic on data; bits pass through unchanged.
- Beat 0 carries label 0 in the LSBs.
- Pointers wrap modulo depth.

Test Plan:
- Single bundle, every horizontal label = 1, every vertical label = 2, out_ready=1:
  - horizontal beats are 0x41041041, 0x10410410, 0x04104104;
  - vertical beats are 0x82082082, 0x20820820, 0x08208208;
  - out_last only on beat 6; first beat one cycle after capture; fifo_count returns to 0.
- Backpressure: out_ready toggled 1,0,0,1,... → each beat is held unchanged across stalls; no beat is lost or repeated; 6 handshakes in total.
- Back-to-back: 3 bundles on consecutive valid cycles, out_ready=1 → 18 contiguous beats with no gap; fifo_count peaks at 3.
- Overflow: out_ready=0 and 5 consecutive valids (depth 4) → fifo_count=4, overflow=1; releasing ready emits bundles 1-4 only, and the 5th is absent.
- Reset mid-operation: assert rst=0 for one cycle during beat 2 of a bundle with 2 queued → next cycle out_valid=0, fifo_count=0, overflow=0; a new bundle then starts at beat 0.
- Wrap-around: 10 bundles with distinct values (label i = bundle index + i) paced to never overflow → all 60 beats match the packing in order as pointers wrap twice.
